// File: rtl/prod_accumulator.sv
// prod_accumulator: frames an 8-bit product stream into bursts and accumulates each into a sum.
// Optional PROD_ACC_SAT_EN: clamp the sum at 2^ACC_W-1 on carry-out instead of wrapping.
module prod_accumulator #(
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {StAcc, StHold} state_e;

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_fire;
  logic             w_close;
  logic             w_carry;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_fire    = in_valid && (r_state == StAcc);
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, in_prod};
  assign w_carry   = w_sum[ACC_W];
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_close   = in_last || (w_cnt_inc == CNT_W'(MAX_BEATS));

`ifdef PROD_ACC_SAT_EN
  // Once clamped, any further non-zero beat carries again, so the clamp is sticky.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StAcc;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (w_fire) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_carry;
            if (w_close) r_state <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= StAcc;
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  assign in_ready  = (r_state == StAcc);
  assign out_valid = (r_state == StHold);
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: directed vector table, corner sequences, random bursts.
module tb_prod_accumulator;

  localparam int unsigned ACC_W     = 8;
  localparam int unsigned MAX_BEATS = 8;
  localparam int unsigned CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int          NB        = 40;
`ifdef PROD_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_prod = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int errors = 0;
  int checks = 0;

  prod_accumulator #(
    .ACC_W    (ACC_W),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              n;
    logic [7:0][7:0] beats;
    logic            last;
    int              exp_sum;
    int              exp_cnt;
    int              exp_ovf;
  } vec_t;

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } res_t;

  vec_t vecs[$];
  res_t exp_q[$];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference result from the true (unbounded) total of a burst.
  function automatic res_t model(input int total, input int cnt);
    res_t r;
    int lim = 1 << ACC_W;
    r.cnt = cnt;
    r.ovf = (total >= lim) ? 1 : 0;
    if (total < lim) r.sum = total;
    else r.sum = Sat ? lim - 1 : total % lim;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input int n, input logic [63:0] b, input logic l);
    vec_t v;
    int total = 0;
    res_t r;
    v.name = nm;
    v.n = n;
    v.beats = b;
    v.last = l;
    for (int j = 0; j < n; j++) total += int'(v.beats[j]);
    r = model(total, n);
    v.exp_sum = r.sum;
    v.exp_cnt = r.cnt;
    v.exp_ovf = r.ovf;
    return v;
  endfunction

  // Call away from posedge; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] p, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " in_ready"}, in_ready, 1);
    check({nm, " out_valid"}, out_valid, 0);
    check({nm, " out_sum"}, out_sum, 0);
    check({nm, " out_count"}, out_count, 0);
    check({nm, " out_ovf"}, out_ovf, 0);
  endtask

  task automatic drive_random;
    for (int b = 0; b < NB; b++) begin
      int   len   = $urandom_range(1, MAX_BEATS);
      int   total = 0;
      logic [7:0] p [MAX_BEATS];
      for (int j = 0; j < len; j++) begin
        p[j] = 8'($urandom_range(0, 255));
        total += int'(p[j]);
      end
      exp_q.push_back(model(total, len));
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send_beat(p[j], j == len - 1);
      end
    end
  endtask

  task automatic monitor_random;
    int got = 0;
    int cyc = 0;
    while (got < NB && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd unexpected_result", 1, 0);
        end else begin
          res_t e = exp_q.pop_front();
          check($sformatf("rnd%0d sum", got), out_sum, e.sum);
          check($sformatf("rnd%0d count", got), out_count, e.cnt);
          check($sformatf("rnd%0d ovf", got), out_ovf, e.ovf);
        end
        got++;
      end
    end
    check("rnd results_received", got, NB);
  endtask

  initial begin
    vecs.push_back(mk("basic", 3, 64'h0000_0000_0010_09E1, 1'b1));
    vecs.push_back(mk("ovf", 2, 64'h0000_0000_0000_02FF, 1'b1));
    vecs.push_back(mk("after_ovf", 1, 64'h0000_0000_0000_0003, 1'b1));
    vecs.push_back(mk("forced", 8, 64'h0101_0101_0101_0101, 1'b0));
    vecs.push_back(mk("beat9", 1, 64'h0000_0000_0000_0001, 1'b1));
    vecs.push_back(mk("last_at_max", 8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
    vecs.push_back(mk("after_max", 1, 64'h0000_0000_0000_0007, 1'b1));

    #1;
    check_reset_outputs("rst_hold");
    #11;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_release");

    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) send_beat(vecs[i].beats[j], vecs[i].last && (j == vecs[i].n - 1));
      @(negedge clk);
      check({vecs[i].name, " out_valid"}, out_valid, 1);
      check({vecs[i].name, " in_ready_hold"}, in_ready, 0);
      check({vecs[i].name, " out_sum"}, out_sum, vecs[i].exp_sum);
      check({vecs[i].name, " out_count"}, out_count, vecs[i].exp_cnt);
      check({vecs[i].name, " out_ovf"}, out_ovf, vecs[i].exp_ovf);
      @(negedge clk);
      check({vecs[i].name, " in_ready_back"}, in_ready, 1);
      check({vecs[i].name, " out_valid_drop"}, out_valid, 0);
    end

    // Back-pressure: pending beat must wait while the result is held.
    out_ready = 1'b0;
    send_beat(8'h20, 1'b0);
    send_beat(8'h20, 1'b1);
    in_valid = 1'b1;
    in_prod  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d out_valid", k), out_valid, 1);
      check($sformatf("bp%0d out_sum", k), out_sum, 8'h40);
      check($sformatf("bp%0d out_count", k), out_count, 2);
      check($sformatf("bp%0d in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp release out_valid", out_valid, 0);
    check("bp release out_sum", out_sum, 0);
    check("bp release out_count", out_count, 0);
    @(negedge clk);
    check("bp single_handshake", out_valid, 0);

    // Reset mid-burst.
    @(posedge clk);
    #1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h11, 1'b0);
    check("mid partial_count", out_count, 2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset during HOLD.
    send_beat(8'h22, 1'b1);
    check("hold before_rst", out_valid, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_hold_state");
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    send_beat(8'h05, 1'b1);
    @(negedge clk);
    check("post_rst out_valid", out_valid, 1);
    check("post_rst out_sum", out_sum, 5);
    check("post_rst out_count", out_count, 1);
    check("post_rst out_ovf", out_ovf, 0);
    @(negedge clk);

    fork
      drive_random();
      monitor_random();
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
